// File: rtl/vscale_htif_pcr_bridge.sv
// vscale_htif_pcr_bridge: byte-serial host link <-> HTIF PCR request/response channel.
// One PCR transaction in flight at a time.
// Optional feature macro: VSCALE_HTIF_WRITE_ACK_EN. When defined, writes return the
// 8-byte read-back response. When undefined, the write response is consumed and dropped.
module vscale_htif_pcr_bridge #(
  parameter  int unsigned TIMEOUT_CYCLES = 0,
  localparam int unsigned HTIF_PCR_WIDTH = 64,
  localparam int unsigned CSR_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      host_in_valid,
  output logic                      host_in_ready,
  input  logic [7:0]                host_in_data,
  output logic                      host_out_valid,
  input  logic                      host_out_ready,
  output logic [7:0]                host_out_data,
  output logic                      htif_pcr_req_valid,
  input  logic                      htif_pcr_req_ready,
  output logic                      htif_pcr_req_rw,
  output logic [CSR_ADDR_WIDTH-1:0] htif_pcr_req_addr,
  output logic [HTIF_PCR_WIDTH-1:0] htif_pcr_req_data,
  input  logic                      htif_pcr_resp_valid,
  output logic                      htif_pcr_resp_ready,
  input  logic [HTIF_PCR_WIDTH-1:0] htif_pcr_resp_data,
  output logic                      busy
);

  localparam int unsigned CNT_WIDTH = 3;
  localparam int unsigned BYTE_W    = 8;
`ifdef VSCALE_HTIF_WRITE_ACK_EN
  localparam bit WRITE_ACK = 1'b1;
`else
  localparam bit WRITE_ACK = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_CMD  = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_REQ  = 3'd3,
    ST_RESP = 3'd4,
    ST_SEND = 3'd5
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic                      rw_q, rw_d;
  logic [CSR_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [HTIF_PCR_WIDTH-1:0] data_q, data_d;
  logic [HTIF_PCR_WIDTH-1:0] shift_q, shift_d;

  logic host_in_ready_q, host_in_ready_d;
  logic host_out_valid_q, host_out_valid_d;
  logic req_valid_q, req_valid_d;
  logic resp_ready_q, resp_ready_d;
  logic busy_q, busy_d;

  logic host_in_fire, host_out_fire, req_fire, resp_fire;
  logic resp_to_host, cnt_last;

  // Reserved link-supervision parameter has no function yet.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 32'd0);

  // Handshake decodes use the registered valid/ready flags, so nothing fires in reset.
  assign host_in_fire  = host_in_valid & host_in_ready_q;
  assign host_out_fire = host_out_valid_q & host_out_ready;
  assign req_fire      = req_valid_q & htif_pcr_req_ready;
  assign resp_fire     = resp_ready_q & htif_pcr_resp_valid;
  assign resp_to_host  = ~rw_q | WRITE_ACK;
  assign cnt_last      = &cnt_q;

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_CMD;
      cnt_q            <= '0;
      rw_q             <= 1'b0;
      addr_q           <= '0;
      data_q           <= '0;
      shift_q          <= '0;
      host_in_ready_q  <= 1'b0;
      host_out_valid_q <= 1'b0;
      req_valid_q      <= 1'b0;
      resp_ready_q     <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      rw_q             <= rw_d;
      addr_q           <= addr_d;
      data_q           <= data_d;
      shift_q          <= shift_d;
      host_in_ready_q  <= host_in_ready_d;
      host_out_valid_q <= host_out_valid_d;
      req_valid_q      <= req_valid_d;
      resp_ready_q     <= resp_ready_d;
      busy_q           <= busy_d;
    end
  end

  // Next-state logic: packet parse, PCR handshake, response serialisation.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CMD:  if (host_in_fire) state_d = ST_ADDR;
      ST_ADDR: if (host_in_fire) state_d = rw_q ? ST_DATA : ST_REQ;
      ST_DATA: if (host_in_fire && cnt_last) state_d = ST_REQ;
      ST_REQ:  if (req_fire) state_d = ST_RESP;
      ST_RESP: if (resp_fire) state_d = resp_to_host ? ST_SEND : ST_CMD;
      ST_SEND: if (host_out_fire && cnt_last) state_d = ST_CMD;
      default: state_d = ST_CMD;
    endcase
  end

  // Datapath: field capture, byte counter and response shift register.
  always_comb begin
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    data_d  = data_q;
    shift_d = shift_q;
    case (state_q)
      ST_CMD: begin
        if (host_in_fire) begin
          rw_d         = host_in_data[7];
          addr_d[11:8] = host_in_data[3:0];
        end
      end
      ST_ADDR: begin
        if (host_in_fire) begin
          addr_d[7:0] = host_in_data;
          cnt_d       = '0;
        end
      end
      ST_DATA: begin
        if (host_in_fire) begin
          data_d[{cnt_q, 3'b000} +: BYTE_W] = host_in_data;
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_RESP: begin
        if (resp_fire && resp_to_host) begin
          shift_d = htif_pcr_resp_data;
          cnt_d   = '0;
        end
      end
      ST_SEND: begin
        if (host_out_fire) begin
          shift_d = shift_q >> BYTE_W;
          cnt_d   = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  // Output decode of the next state, registered so outputs stay low through reset.
  always_comb begin
    host_in_ready_d  = 1'b0;
    host_out_valid_d = 1'b0;
    req_valid_d      = 1'b0;
    resp_ready_d     = 1'b0;
    case (state_d)
      ST_CMD, ST_ADDR, ST_DATA: host_in_ready_d  = 1'b1;
      ST_REQ:                   req_valid_d      = 1'b1;
      ST_RESP:                  resp_ready_d     = 1'b1;
      ST_SEND:                  host_out_valid_d = 1'b1;
      default: ;
    endcase
    busy_d = (state_d != ST_CMD);
  end

  assign host_in_ready       = host_in_ready_q;
  assign host_out_valid      = host_out_valid_q;
  assign host_out_data       = shift_q[BYTE_W-1:0];
  assign htif_pcr_req_valid  = req_valid_q;
  assign htif_pcr_req_rw     = rw_q;
  assign htif_pcr_req_addr   = addr_q;
  assign htif_pcr_req_data   = data_q;
  assign htif_pcr_resp_ready = resp_ready_q;
  assign busy                = busy_q;

endmodule
